// File: rtl/dn_router_pipe.sv
// Distribution-network switch node: per-output lane select from a registered config, then a 2-entry skid buffer.
// Latency 1 cycle when empty; in_ready drops when both entries are full. Optional per-output masking under DN_ROUTER_MASK_EN.
module dn_router_pipe #(
  parameter int  DW_DATA  = 32,
  parameter int  NUM_PORT = 2,
  localparam int SEL_W    = $clog2(NUM_PORT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        set_en,
  input  logic [NUM_PORT*SEL_W-1:0]   route_signal,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW_DATA*NUM_PORT-1:0] in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW_DATA*NUM_PORT-1:0] out,
`ifdef DN_ROUTER_MASK_EN
  input  logic [NUM_PORT-1:0]         out_mask,
`endif
  output logic [15:0]                 beat_cnt
);

  localparam int LW = DW_DATA * NUM_PORT;

  function automatic logic [NUM_PORT*SEL_W-1:0] identity_cfg();
    logic [NUM_PORT*SEL_W-1:0] r;
    r = '0;
    for (int o = 0; o < NUM_PORT; o++) begin
      r[o*SEL_W +: SEL_W] = SEL_W'(o);
    end
    return r;
  endfunction

  localparam logic [NUM_PORT*SEL_W-1:0] CFG_ID = identity_cfg();

  logic [NUM_PORT*SEL_W-1:0] cfg_q, cfg_d;
  logic [LW-1:0]             buf0_q, buf0_d;
  logic [LW-1:0]             buf1_q, buf1_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [15:0]               beat_cnt_q, beat_cnt_d;
  logic [LW-1:0]             routed;
  logic                      push, pop;

  assign in_ready  = (cnt_q != 2'd2) & ~reset;
  assign out_valid = (cnt_q != 2'd0);
  assign out       = out_valid ? buf0_q : '0;
  assign beat_cnt  = beat_cnt_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Out-of-range selects match no input and leave the lane at zero.
  always_comb begin
    routed = '0;
    for (int o = 0; o < NUM_PORT; o++) begin
      for (int i = 0; i < NUM_PORT; i++) begin
        if (cfg_q[o*SEL_W +: SEL_W] == SEL_W'(i)) begin
          routed[o*DW_DATA +: DW_DATA] = in[i*DW_DATA +: DW_DATA];
        end
      end
`ifdef DN_ROUTER_MASK_EN
      if (!out_mask[o]) begin
        routed[o*DW_DATA +: DW_DATA] = '0;
      end
`endif
    end
  end

  always_comb begin
    cfg_d      = set_en ? route_signal : cfg_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    cnt_d      = cnt_q;
    beat_cnt_d = pop ? beat_cnt_q + 16'd1 : beat_cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = routed;
        else               buf1_d = routed;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        buf1_d = '0;
        cnt_d  = cnt_q - 2'd1;
      end
      // Push and pop together only happens at count 1: the new beat replaces the head.
      2'b11: buf0_d = routed;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q      <= CFG_ID;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= 2'd0;
      beat_cnt_q <= 16'd0;
    end else begin
      cfg_q      <= cfg_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_dn_router_pipe.sv
// Directed bench for dn_router_pipe (DW_DATA=32, NUM_PORT=2); mask expectations follow DN_ROUTER_MASK_EN.
module tb_dn_router_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_en = 1'b0;
  logic [1:0]  route_signal = 2'b10;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_dat = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_dat;
  logic [15:0] beat_cnt;
`ifdef DN_ROUTER_MASK_EN
  logic [1:0]  out_mask = 2'b11;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;

  localparam logic [63:0] B1 = 64'h00000101_00000100;
  localparam logic [63:0] B2 = 64'h00000201_00000200;
  localparam logic [63:0] B3 = 64'h00000301_00000300;

  dn_router_pipe #(.DW_DATA(32), .NUM_PORT(2)) dut (
    .clk(clk), .reset(reset), .set_en(set_en), .route_signal(route_signal),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_dat),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_dat),
`ifdef DN_ROUTER_MASK_EN
    .out_mask(out_mask),
`endif
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_dat !== 64'h0) begin n_fail++; $display("FAIL rst_out: got %h want 0", out_dat); end
    n_checks++; if (beat_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_beat_cnt: got %h want 0", beat_cnt); end
    reset = 1'b0;
    exp_cnt = 16'd0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_identity();
    in_dat = 64'h0000000B_0000000A;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL id_valid: got %b want 1", out_valid); end
    n_checks++; if (out_dat !== 64'h0000000B_0000000A) begin n_fail++; $display("FAIL id_out: got %h want 0000000b0000000a", out_dat); end
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_dat !== 64'h0) begin n_fail++; $display("FAIL id_empty: got v=%b out=%h want v=0 out=0", out_valid, out_dat); end
    n_checks++; if (beat_cnt !== exp_cnt) begin n_fail++; $display("FAIL id_cnt: got %h want %h", beat_cnt, exp_cnt); end
  endtask

  task automatic test_config();
    out_ready = 1'b1;
    set_en = 1'b1;
    route_signal = 2'b00;
    in_valid = 1'b1;
    in_dat = 64'h00000044_00000033;
    tick();
    set_en = 1'b0;
    in_dat = 64'h00000022_00000011;
    n_checks++; if (out_dat !== 64'h00000044_00000033) begin n_fail++; $display("FAIL cfg_old_route: got %h want 0000004400000033", out_dat); end
    tick();
    exp_cnt++;
    n_checks++; if (out_dat !== 64'h00000011_00000011) begin n_fail++; $display("FAIL cfg_broadcast: got %h want 0000001100000011", out_dat); end
    in_valid = 1'b0;
    set_en = 1'b1;
    route_signal = 2'b01;
    tick();
    exp_cnt++;
    set_en = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL cfg_drained: got %b want 0", out_valid); end
    in_valid = 1'b1;
    in_dat = 64'h00000022_00000011;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_dat !== 64'h00000011_00000022) begin n_fail++; $display("FAIL cfg_swap: got %h want 0000001100000022", out_dat); end
    tick();
    exp_cnt++;
    set_en = 1'b1;
    route_signal = 2'b10;
    tick();
    set_en = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (beat_cnt !== exp_cnt) begin n_fail++; $display("FAIL cfg_cnt: got %h want %h", beat_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_dat = B1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_c1: got %b want 1", in_ready); end
    in_dat = B2;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b want 0", in_ready); end
    n_checks++; if (out_dat !== B1) begin n_fail++; $display("FAIL bp_head: got %h want %h", out_dat, B1); end
    in_dat = B3;
    tick();
    n_checks++; if (in_ready !== 1'b0 || out_dat !== B1) begin n_fail++; $display("FAIL bp_hold: got rdy=%b out=%h want rdy=0 out=%h", in_ready, out_dat, B1); end
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    n_checks++; if (out_dat !== B2 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop1: got rdy=%b out=%h want rdy=1 out=%h", in_ready, out_dat, B2); end
    tick();
    exp_cnt++;
    n_checks++; if (out_dat !== B3) begin n_fail++; $display("FAIL bp_third: got %h want %h", out_dat, B3); end
    n_checks++; if (beat_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_cnt: got %h want %h", beat_cnt, exp_cnt); end
    in_valid = 1'b0;
    tick();
    exp_cnt++;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] base;
    logic [63:0] exp_beat;
    base = exp_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_dat = {32'hC0000000, 32'hD0000000};
    tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      exp_beat = {32'hC0000000 + 32'(k), 32'hD0000000 + 32'(k)};
      in_dat = exp_beat;
      tick();
      exp_cnt++;
      n_checks++;
      if (out_dat !== exp_beat || in_ready !== 1'b1 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got v=%b rdy=%b out=%h want v=1 rdy=1 out=%h", k, out_valid, in_ready, out_dat, exp_beat);
      end
    end
    n_checks++; if (beat_cnt !== base + 16'd10) begin n_fail++; $display("FAIL b2b_cnt: got %h want %h", beat_cnt, base + 16'd10); end
    in_valid = 1'b0;
    tick();
    exp_cnt++;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_en = 1'b1;
    route_signal = 2'b00;
    in_dat = B1;
    tick();
    set_en = 1'b0;
    in_dat = B2;
    tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b want 0", in_ready); end
    reset = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_dat !== 64'h0) begin n_fail++; $display("FAIL mid_rst_out: got v=%b out=%h want v=0 out=0", out_valid, out_dat); end
    n_checks++; if (beat_cnt !== 16'h0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cnt: got cnt=%h rdy=%b want cnt=0 rdy=0", beat_cnt, in_ready); end
    reset = 1'b0;
    exp_cnt = 16'd0;
    in_valid = 1'b1;
    in_dat = 64'h00000022_00000011;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_dat !== 64'h00000022_00000011) begin n_fail++; $display("FAIL mid_identity: got %h want 0000002200000011", out_dat); end
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    out_ready = 1'b0;
    n_checks++; if (beat_cnt !== exp_cnt || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after: got cnt=%h v=%b want cnt=%h v=0", beat_cnt, out_valid, exp_cnt); end
  endtask

  task automatic test_mask();
    logic [63:0] exp_out;
`ifdef DN_ROUTER_MASK_EN
    out_mask = 2'b10;
    exp_out = 64'h000000BB_00000000;
`else
    exp_out = 64'h000000BB_000000AA;
`endif
    in_dat = 64'h000000BB_000000AA;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_dat !== exp_out) begin n_fail++; $display("FAIL mask_out: got %h want %h", out_dat, exp_out); end
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    out_ready = 1'b0;
`ifdef DN_ROUTER_MASK_EN
    out_mask = 2'b11;
`endif
    n_checks++; if (beat_cnt !== exp_cnt) begin n_fail++; $display("FAIL mask_cnt: got %h want %h", beat_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_config();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
